// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and constants for the forwarding/hazard unit.
// Stage entries carry rd at REG_W_MAX bits so one struct serves every REG_W up to 8.
package fwd_pkg;

    localparam int unsigned REG_W_DEF  = 32'd5;
    localparam int unsigned REG_W_MAX  = 32'd8;
    localparam int unsigned FWD_SEL_RF = 32'd0;

    typedef struct packed {
        logic                 valid;
        logic [REG_W_MAX-1:0] rd;
        logic                 regwrite;
        logic                 memread;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-side request and EX-side forwarding/stall response bundle.
// The datapath drives the master modport; the hazard unit drives the slave modport.
interface fwd_hazard_unit_if
    import fwd_pkg::*;
#(
    parameter int unsigned REG_W   = REG_W_DEF,
    parameter int unsigned NUM_SRC = 32'd2,
    parameter int unsigned SEL_W   = 32'd2
);

    logic                     id_valid_i;
    logic [NUM_SRC*REG_W-1:0] id_rs_i;
    logic [NUM_SRC-1:0]       id_rs_used_i;
    logic [REG_W-1:0]         id_rd_i;
    logic                     id_regwrite_i;
    logic                     id_memread_i;
    logic                     flush_i;
    logic                     stall_o;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel_o;
    logic                     ex_valid_o;

    modport master (
        output id_valid_i, id_rs_i, id_rs_used_i, id_rd_i,
        output id_regwrite_i, id_memread_i, flush_i,
        input  stall_o, fwd_sel_o, ex_valid_o
    );

    modport slave (
        input  id_valid_i, id_rs_i, id_rs_used_i, id_rd_i,
        input  id_regwrite_i, id_memread_i, flush_i,
        output stall_o, fwd_sel_o, ex_valid_o
    );

endinterface

// File: rtl/fwd_hazard_unit_prio_sel.sv
// Youngest-producer priority encoder: bit i of i_match is stage i+1; the lowest
// set bit wins and is reported as its stage number, 0 when nothing matches.
module fwd_prio_sel #(
    parameter int unsigned N     = 32'd3,
    parameter int unsigned SEL_W = 32'd2
) (
    input  logic [N-1:0]     i_match,
    output logic [SEL_W-1:0] o_sel
);

    logic w_found;

    // Scan from the youngest stage outward and latch the first hit.
    always_comb begin
        o_sel   = '0;
        w_found = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (i_match[i] && !w_found) begin
                o_sel   = SEL_W'(i + 1);
                w_found = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select / load-use stall unit over a DEPTH-stage shadow pipeline.
// Optional FWD_HAZARD_STATS_EN adds saturating stall and forward counters.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned REG_W    = REG_W_DEF,
    parameter int unsigned NUM_SRC  = 32'd2,
    parameter int unsigned DEPTH    = 32'd4,
    parameter int unsigned LOAD_LAT = 32'd2,
    parameter int unsigned SEL_W    = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    fwd_hazard_unit_if.slave    bus
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [31:0]         stall_cnt_o,
    output logic [31:0]         fwd_cnt_o
`endif
);

    stage_t                   r_stg [DEPTH];
    logic [REG_W-1:0]         r_rs [NUM_SRC];
    logic [NUM_SRC-1:0]       r_rs_used;

    logic                     w_stall;
    logic                     w_bubble;
    logic [DEPTH-2:0]         w_match [NUM_SRC];
    logic [SEL_W-1:0]         w_sel [NUM_SRC];
    logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;

    // Load-use check: a load that will still be short of LOAD_LAT when the ID instruction reaches EX.
    always_comb begin
        w_stall = 1'b0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            for (int s = 0; s < int'(LOAD_LAT) - 1; s++) begin
                w_stall = w_stall | (bus.id_valid_i && !bus.flush_i && bus.id_rs_used_i[k]
                          && (bus.id_rs_i[k*REG_W +: REG_W] != '0)
                          && r_stg[s].valid && r_stg[s].memread
                          && (r_stg[s].rd == REG_W_MAX'(bus.id_rs_i[k*REG_W +: REG_W])));
            end
        end
    end

    assign w_bubble = bus.flush_i | w_stall;

    // Per-source match vector over stages 1..DEPTH-1; loads younger than LOAD_LAT are masked.
    always_comb begin
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            w_match[k] = '0;
            for (int s = 1; s < int'(DEPTH); s++) begin
                w_match[k][s-1] = r_stg[s].valid && r_stg[s].regwrite
                                  && (r_stg[s].rd != '0)
                                  && (r_stg[s].rd == REG_W_MAX'(r_rs[k]))
                                  && r_rs_used[k]
                                  && !(r_stg[s].memread && (s < int'(LOAD_LAT)));
            end
        end
    end

    for (genvar k = 0; k < int'(NUM_SRC); k++) begin : g_src
        fwd_prio_sel #(
            .N     (DEPTH - 32'd1),
            .SEL_W (SEL_W)
        ) u_prio_sel (
            .i_match (w_match[k]),
            .o_sel   (w_sel[k])
        );
        assign w_fwd_sel[k*SEL_W +: SEL_W] = w_sel[k];
    end

    // Shadow pipeline: free-running shift, stage 0 takes ID fields or a bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < int'(DEPTH); s++) begin
                r_stg[s] <= STAGE_BUBBLE;
            end
            for (int k = 0; k < int'(NUM_SRC); k++) begin
                r_rs[k] <= '0;
            end
            r_rs_used <= '0;
        end else begin
            for (int s = int'(DEPTH) - 1; s > 0; s--) begin
                r_stg[s] <= r_stg[s-1];
            end
            if (w_bubble) begin
                r_stg[0] <= STAGE_BUBBLE;
                for (int k = 0; k < int'(NUM_SRC); k++) begin
                    r_rs[k] <= '0;
                end
                r_rs_used <= '0;
            end else begin
                r_stg[0] <= '{valid:    bus.id_valid_i,
                              rd:       REG_W_MAX'(bus.id_rd_i),
                              regwrite: bus.id_valid_i & bus.id_regwrite_i,
                              memread:  bus.id_valid_i & bus.id_memread_i};
                for (int k = 0; k < int'(NUM_SRC); k++) begin
                    r_rs[k] <= bus.id_rs_i[k*REG_W +: REG_W];
                end
                r_rs_used <= bus.id_rs_used_i & {NUM_SRC{bus.id_valid_i}};
            end
        end
    end

    assign bus.stall_o    = w_stall;
    assign bus.fwd_sel_o  = w_fwd_sel;
    assign bus.ex_valid_o = r_stg[0].valid;

`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_fwd_cnt;
    logic        w_fwd_any;

    assign w_fwd_any = r_stg[0].valid && (|w_fwd_sel);

    // Saturating event counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= 32'd0;
            r_fwd_cnt   <= 32'd0;
        end else begin
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_fwd_any && (r_fwd_cnt != 32'hFFFF_FFFF)) begin
                r_fwd_cnt <= r_fwd_cnt + 32'd1;
            end else begin
                r_fwd_cnt <= r_fwd_cnt;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign fwd_cnt_o   = r_fwd_cnt;
`endif

endmodule
